// File: rtl/decode_issue_controller_if.sv
// ----------------------------------------------------------------------------
// decode_issue_pkg / decode_issue_if
//
// decode_issue_pkg holds the instruction/PC widths, the decoded opcode class
// and the decoded_instruction_t record handed from decode to execute.
//
// decode_issue_if bundles the decode stage's handshake and bus signals:
//   in_valid/in_ready/in_instr/in_pc       fetch -> decode handshake
//   out_valid/out_ready/out_pc/out_decoded decode -> execute handshake
//   wb_valid/wb_rd                         register write retiring
//   flush                                  redirect, discard held instruction
// Modports: master = environment side (fetch/execute/writeback),
//           slave  = the decode_issue_controller.
// ----------------------------------------------------------------------------
package decode_issue_pkg;

    localparam int ILEN = 32;
    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        OPCODE_LUI,
        OPCODE_AUIPC,
        OPCODE_JAL,
        OPCODE_JALR,
        OPCODE_BRANCH,
        OPCODE_LOAD,
        OPCODE_STORE,
        OPCODE_OP_IMM,
        OPCODE_OP,
        OPCODE_UNKNOWN
    } opcode_e;

    typedef struct packed {
        opcode_e         opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [XLEN-1:0] i_imm;
        logic [XLEN-1:0] s_imm;
        logic [XLEN-1:0] b_imm;
        logic [XLEN-1:0] u_imm;
        logic [XLEN-1:0] j_imm;
    } decoded_instruction_t;

endpackage

interface decode_issue_if;

    logic                                   in_valid;
    logic                                   in_ready;
    logic [decode_issue_pkg::ILEN-1:0]      in_instr;
    logic [decode_issue_pkg::XLEN-1:0]      in_pc;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [decode_issue_pkg::XLEN-1:0]      out_pc;
    decode_issue_pkg::decoded_instruction_t out_decoded;
    logic                                   wb_valid;
    logic [4:0]                             wb_rd;
    logic                                   flush;

    modport master (
        output in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd, flush,
        input  in_ready, out_valid, out_pc, out_decoded
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready, wb_valid, wb_rd, flush,
        output in_ready, out_valid, out_pc, out_decoded
    );

endinterface

// File: rtl/decode_issue_controller.sv
// ----------------------------------------------------------------------------
// decode_issue_controller
//
// Decode-stage sequencer. One holding slot captures a fetched instruction,
// instruction_decoder decodes it, and a per-register scoreboard of in-flight
// writes blocks issue on RAW hazards (and on counter saturation). Writeback
// retires scoreboard entries; flush empties the slot but keeps the counts.
//
// Ports:
//   clk            sole clock, rising edge
//   reset_n        asynchronous active-low reset
//   bus            decode_issue_if.slave (fetch, execute, writeback, flush)
//   stall_cycles   [31:0] cycles spent holding a hazard-stalled instruction
//                  (present only when DECODE_STALL_COUNTER_EN is defined)
//
// Parameters:
//   SB_CNT_W       width of each outstanding-write counter (max 2^SB_CNT_W-1)
//
// Optional feature macro: DECODE_STALL_COUNTER_EN
// ----------------------------------------------------------------------------

// Pure field extraction plus opcode classification for RV32I base opcodes.
module instruction_decoder
    import decode_issue_pkg::*;
(
    input  logic [ILEN-1:0]      instr,
    output decoded_instruction_t decoded
);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        decoded        = '0;
        decoded.rd     = instr[11:7];
        decoded.rs1    = instr[19:15];
        decoded.rs2    = instr[24:20];
        decoded.funct3 = instr[14:12];
        decoded.funct7 = instr[31:25];
        decoded.i_imm  = {{20{instr[31]}}, instr[31:20]};
        decoded.s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        decoded.b_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        decoded.u_imm  = {instr[31:12], 12'b0};
        decoded.j_imm  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        case (instr[6:0])
            7'b0110111: decoded.opcode = OPCODE_LUI;
            7'b0010111: decoded.opcode = OPCODE_AUIPC;
            7'b1101111: decoded.opcode = OPCODE_JAL;
            7'b1100111: decoded.opcode = OPCODE_JALR;
            7'b1100011: decoded.opcode = OPCODE_BRANCH;
            7'b0000011: decoded.opcode = OPCODE_LOAD;
            7'b0100011: decoded.opcode = OPCODE_STORE;
            7'b0010011: decoded.opcode = OPCODE_OP_IMM;
            7'b0110011: decoded.opcode = OPCODE_OP;
            default:    decoded.opcode = OPCODE_UNKNOWN;
        endcase
    end

endmodule

module decode_issue_controller
    import decode_issue_pkg::*;
#(
    parameter int SB_CNT_W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    decode_issue_if.slave bus
`ifdef DECODE_STALL_COUNTER_EN
    ,
    output logic [31:0]  stall_cycles
`endif
);

    typedef enum logic {
        ST_EMPTY,
        ST_HOLD
    } state_e;

    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;

    state_e               state_q, state_d;
    logic [ILEN-1:0]      instr_q;
    logic [XLEN-1:0]      pc_q;
    decoded_instruction_t dec;

    // One outstanding-write counter per architectural register; entry 0 is
    // never written because x0 is never tracked.
    logic [SB_CNT_W-1:0]  cnt_q [32];

    logic rs1_used, rs2_used, rd_written, hazard;
    logic out_valid, issue, in_ready, accept;
    logic [31:0] inc_vec, dec_vec;

    instruction_decoder u_decoder (
        .instr   (instr_q),
        .decoded (dec)
    );

    // ------------------------------------------------------------------
    // Register usage and hazard detection for the held instruction.
    // ------------------------------------------------------------------
    always_comb begin
        rs1_used   = (dec.opcode inside {OPCODE_JALR, OPCODE_OP_IMM, OPCODE_OP,
                                         OPCODE_BRANCH, OPCODE_LOAD, OPCODE_STORE})
                     && (dec.rs1 != 5'd0);
        rs2_used   = (dec.opcode inside {OPCODE_OP, OPCODE_BRANCH, OPCODE_STORE})
                     && (dec.rs2 != 5'd0);
        rd_written = (dec.opcode inside {OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR,
                                         OPCODE_OP_IMM, OPCODE_OP, OPCODE_LOAD})
                     && (dec.rd != 5'd0);
        // The rd term stalls a writer whose counter is already saturated, so
        // an issue can never overflow it.
        hazard     = (rs1_used   && (cnt_q[dec.rs1] != '0))
                  || (rs2_used   && (cnt_q[dec.rs2] != '0))
                  || (rd_written && (cnt_q[dec.rd]  == CNT_MAX));
    end

    // ------------------------------------------------------------------
    // Handshakes and next-state logic. Flush masks both handshakes.
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (state_q == ST_HOLD) && !hazard && !bus.flush;
        issue     = out_valid && bus.out_ready;
        // Pass-through: the slot frees in the same cycle it issues.
        in_ready  = (state_q == ST_EMPTY) || issue;
        accept    = bus.in_valid && in_ready && !bus.flush;

        state_d = state_q;
        if (bus.flush)
            state_d = ST_EMPTY;
        else if (accept)
            state_d = ST_HOLD;
        else if (issue)
            state_d = ST_EMPTY;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                instr_q <= bus.in_instr;
                pc_q    <= bus.in_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard. An issue and a writeback on the same register in the
    // same cycle cancel; a lone writeback at zero is ignored.
    // ------------------------------------------------------------------
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 1; i < 32; i++) begin
            inc_vec[i] = issue && rd_written && (dec.rd == 5'(i));
            dec_vec[i] = bus.wb_valid && (bus.wb_rd == 5'(i));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: this array is reset, unlike a data RAM, because the counts
        // are control state that must start at zero for hazards to be right.
        if (!reset_n) begin
            for (int i = 0; i < 32; i++)
                cnt_q[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    cnt_q[i] <= cnt_q[i] + SB_CNT_W'(1);
                else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != '0))
                    cnt_q[i] <= cnt_q[i] - SB_CNT_W'(1);
            end
        end
    end

`ifdef DECODE_STALL_COUNTER_EN
    // Counts cycles in which a held instruction is blocked by a hazard;
    // wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cycles <= '0;
        else if ((state_q == ST_HOLD) && hazard && !bus.flush)
            stall_cycles <= stall_cycles + 32'd1;
    end
`endif

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_pc      = pc_q;
    assign bus.out_decoded = dec;

endmodule

// File: doc/decode_issue_controller.md
# decode_issue_controller

Decode-stage sequencer between instruction fetch and execute. It captures one fetched instruction into a holding slot and decodes it through `instruction_decoder`. A per-register scoreboard of in-flight writes blocks issue on RAW hazards, and the block issues the decoded instruction to execute over a valid/ready handshake. Writeback retires scoreboard entries, and a flush input discards the held instruction on a redirect.

## Interface
Parameters:
- `SB_CNT_W`, 2: width of each per-register outstanding-write counter; max count is 2^SB_CNT_W-1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch offers an instruction.
- `in_ready`  out  1  slot can accept this cycle.
- `in_instr`  in  ILEN  raw instruction bits.
- `in_pc`  in  XLEN  PC of `in_instr`.
- `out_valid`  out  1  decoded instruction issuable.
- `out_ready`  in  1  execute accepts.
- `out_pc`  out  XLEN  PC of held instruction.
- `out_decoded`  out  decoded_instruction_t  decoder output for held instruction.
- `wb_valid`  in  1  one register write retiring.
- `wb_rd`  in  5  destination of retiring write.
- `flush`  in  1  discard held instruction and any incoming one.

## Operation
- FSM has two states. EMPTY holds no instruction; HOLD holds one in `instr_q`/`pc_q`, which drive the decoder.
- rs1 is read by JALR, OP_IMM, OP, BRANCH, LOAD, STORE.
- rs2 is read by OP, BRANCH, STORE.
- rd is written by LUI, AUIPC, JAL, JALR, OP_IMM, OP, LOAD, only when rd != 0.
- x0 never hazards and is never counted.
- hazard = (rs1 used and cnt[rs1] != 0) or (rs2 used and cnt[rs2] != 0) or (rd written and cnt[rd] == max). The last term is a saturation stall.
- OPCODE_UNKNOWN uses no registers and issues unconditionally; execute traps it.
- out_valid = HOLD and not hazard and not flush.
- Issue = out_valid and out_ready. On issue, cnt[rd] increments if rd is written.
- wb_valid with wb_rd != 0 decrements cnt[wb_rd]. A decrement at 0 is ignored and the counter stays 0.
- Issue increment and wb decrement on the same register in the same cycle leave the count unchanged.
- Accept = in_valid and in_ready and not flush. An accept loads `instr_q`/`pc_q` and sets the state to HOLD.
- in_ready = EMPTY or issue (pass-through), giving back-to-back issue of one instruction per cycle.
- HOLD to EMPTY on issue without accept, or on flush.
- EMPTY to HOLD on accept.
- HOLD stays HOLD while stalled, or on issue with simultaneous accept.
- Flush clears the slot only; scoreboard counts persist. Every issued rd-writing instruction, including ones squashed downstream, must produce exactly one wb pulse.

## Timing
- Reset: state EMPTY, all cnt = 0, `instr_q`/`pc_q` = 0, out_valid = 0, in_ready = 1.
- Accept-to-out_valid latency is 1 cycle when no hazard.
- Scoreboard state is registered. A wb in cycle N clears the hazard for issue in cycle N+1; there is no same-cycle wb bypass.
- Issue in cycle N makes dependent instructions see cnt != 0 from cycle N+1.
- Flush overrides both handshakes in its cycle: no accept, no issue, no counter increment. The wb decrement still applies.
- reset_n assertion mid-stall returns all state to reset values immediately, asynchronously.

## Configuration
- `DECODE_STALL_COUNTER_EN` defined: adds output `stall_cycles` (out, 32), counting cycles with HOLD and hazard and not flush.
  - Reset to 0; wraps modulo 2^32.
- `DECODE_STALL_COUNTER_EN` undefined: no port, no counter logic. Behaviour is otherwise identical.

## Test plan
- Reset, then feed `addi x1,x0,5` at PC 0x0 with out_ready=1 -> out_valid at cycle+1, out_pc=0x0, opcode OP_IMM, i_imm 5, then cnt[x1]=1.
- `addi x1,x0,5` then `add x2,x1,x1` with no wb -> second held, out_valid=0.
  - Pulse wb_rd=1 -> out_valid next cycle.
  - With `DECODE_STALL_COUNTER_EN`, stall_cycles equals the stall length.
- Stream of 4 independent instructions with in_valid and out_ready held 1 -> one issue per cycle, in_ready stays 1.
- SB_CNT_W=2, issue 3 writes to x5 with no wb -> fourth write to x5 stalls (saturation).
  - One wb_rd=5 -> the fourth issues on the next cycle.
- Hazard-stalled instruction plus flush -> state EMPTY, no issue; a flush with in_valid=1 in the same cycle is not accepted.
- Issue of a write to x3 in the same cycle as wb_rd=3 with cnt[x3]=1 -> cnt[x3] stays 1. Also, wb_rd=0 or wb with cnt=0 leaves all counts unchanged.
